// File: rtl/audio_tone_mon_pkg.sv
// Shared types and constants for the per-channel audio tone monitor.
package audio_tone_mon_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } mon_state_t;

endpackage

// File: rtl/audio_chan_mon.sv
// One audio channel: power-of-two moving average, rising zero-crossing
// detection, period/peak measurement and saturating window error counts.
module audio_chan_mon
  import audio_tone_mon_pkg::*;
#(
  parameter int SMOOTH_LOG2 = 0,
  parameter int CNT_W       = 16,
  parameter int MIN_PERIOD  = 6,
  parameter int MAX_PERIOD  = 10,
  parameter int MIN_AMPL    = 9600,
  parameter int MAX_AMPL    = 16000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                smpl_vld,
  input  logic [SAMPLE_W-1:0] smpl,
  output logic                meas_vld,
  output logic [CNT_W-1:0]    period,
  output logic [SAMPLE_W-1:0] peak,
  output logic [CNT_W-1:0]    freq_err,
  output logic [CNT_W-1:0]    ampl_err
);

  localparam int DEPTH = 1 << SMOOTH_LOG2;
  localparam int SUM_W = SAMPLE_W + SMOOTH_LOG2;
  localparam int PTR_W = (SMOOTH_LOG2 == 0) ? 1 : SMOOTH_LOG2;
  localparam logic [PTR_W-1:0]           PTR_LAST    = PTR_W'(DEPTH - 1);
  localparam logic [4:0]                 FILL_LAST   = 5'(DEPTH - 1);
  localparam logic [CNT_W-1:0]           CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]           CNT_TIMEOUT = CNT_MAX - 1'b1;
  localparam logic [CNT_W-1:0]           MIN_P       = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]           MAX_P       = CNT_W'(MAX_PERIOD);
  localparam logic signed [SAMPLE_W-1:0] MIN_A       = SAMPLE_W'(MIN_AMPL);
  localparam logic signed [SAMPLE_W-1:0] MAX_A       = SAMPLE_W'(MAX_AMPL);

  logic signed [SAMPLE_W-1:0] ring_q [DEPTH];
  logic signed [SAMPLE_W-1:0] ring_d [DEPTH];
  logic [PTR_W-1:0]           wptr_q, wptr_d;
  logic signed [SUM_W-1:0]    sum_q, sum_d;
  logic signed [SAMPLE_W-1:0] sm_q, sm_d, sm_prev_q, sm_prev_d;
  logic                       sm_vld_q, sm_vld_d;
  logic signed [SAMPLE_W-1:0] pk_q, pk_d, peak_q, peak_d;
  logic [4:0]                 fill_q, fill_d;
  mon_state_t                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, period_q, period_d;
  logic [CNT_W-1:0]           freq_err_q, freq_err_d, ampl_err_q, ampl_err_d;
  logic                       meas_vld_q, meas_vld_d;
  logic signed [SAMPLE_W-1:0] smpl_s;
  logic                       xing;

  assign smpl_s = smpl;

  // Running sum swaps the oldest ring entry for the new sample.
  always_comb begin
    ring_d   = ring_q;
    wptr_d   = wptr_q;
    sum_d    = sum_q;
    sm_d     = sm_q;
    sm_vld_d = 1'b0;
    if (smpl_vld) begin
      sum_d          = sum_q + SUM_W'(smpl_s) - SUM_W'(ring_q[wptr_q]);
      ring_d[wptr_q] = smpl_s;
      wptr_d         = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      sm_d           = SAMPLE_W'(sum_d >>> SMOOTH_LOG2);
      sm_vld_d       = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    pk_d       = pk_q;
    sm_prev_d  = sm_prev_q;
    period_d   = period_q;
    peak_d     = peak_q;
    freq_err_d = freq_err_q;
    ampl_err_d = ampl_err_q;
    meas_vld_d = 1'b0;
    xing       = sm_prev_q[SAMPLE_W-1] & ~sm_q[SAMPLE_W-1];
    if (sm_vld_q) begin
      sm_prev_d = sm_q;
      unique case (state_q)
        FILL: begin
          if (fill_q == FILL_LAST) state_d = ARM;
          else                     fill_d  = fill_q + 1'b1;
        end
        ARM: begin
          if (xing) begin
            cnt_d   = CNT_W'(1);
            pk_d    = sm_q;
            state_d = MEAS;
          end
        end
        MEAS: begin
          if (xing) begin
            meas_vld_d = 1'b1;
            period_d   = cnt_q;
            peak_d     = pk_q;
            if ((cnt_q < MIN_P || cnt_q > MAX_P) && freq_err_q != CNT_MAX)
              freq_err_d = freq_err_q + 1'b1;
            if ((pk_q < MIN_A || pk_q > MAX_A) && ampl_err_q != CNT_MAX)
              ampl_err_d = ampl_err_q + 1'b1;
            cnt_d = CNT_W'(1);
            pk_d  = sm_q;
          end else if (cnt_q == CNT_TIMEOUT) begin
            // Tone vanished: count one frequency error and rearm.
            if (freq_err_q != CNT_MAX) freq_err_d = freq_err_q + 1'b1;
            state_d = ARM;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (sm_q > pk_q) pk_d = sm_q;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wptr_q     <= '0;
      sum_q      <= '0;
      sm_q       <= '0;
      sm_vld_q   <= 1'b0;
      sm_prev_q  <= '0;
      pk_q       <= '0;
      peak_q     <= '0;
      fill_q     <= '0;
      state_q    <= FILL;
      cnt_q      <= '0;
      period_q   <= '0;
      freq_err_q <= '0;
      ampl_err_q <= '0;
      meas_vld_q <= 1'b0;
    end else begin
      ring_q     <= ring_d;
      wptr_q     <= wptr_d;
      sum_q      <= sum_d;
      sm_q       <= sm_d;
      sm_vld_q   <= sm_vld_d;
      sm_prev_q  <= sm_prev_d;
      pk_q       <= pk_d;
      peak_q     <= peak_d;
      fill_q     <= fill_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      freq_err_q <= freq_err_d;
      ampl_err_q <= ampl_err_d;
      meas_vld_q <= meas_vld_d;
    end
  end

  assign meas_vld = meas_vld_q;
  assign period   = period_q;
  assign peak     = peak_q;
  assign freq_err = freq_err_q;
  assign ampl_err = ampl_err_q;

endmodule

// File: rtl/audio_tone_mon.sv
// Stereo tone monitor: two independent channel monitors on the equalizer output.
module audio_tone_mon
  import audio_tone_mon_pkg::*;
#(
  parameter int SMOOTH_LOG2 = 0,
  parameter int CNT_W       = 16,
  parameter int MIN_PERIOD  = 6,
  parameter int MAX_PERIOD  = 10,
  parameter int MIN_AMPL    = 9600,
  parameter int MAX_AMPL    = 16000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                smpl_vld,
  input  logic [SAMPLE_W-1:0] lft_smpl,
  input  logic [SAMPLE_W-1:0] rht_smpl,
  output logic                lft_meas_vld,
  output logic                rht_meas_vld,
  output logic [CNT_W-1:0]    lft_period,
  output logic [CNT_W-1:0]    rht_period,
  output logic [SAMPLE_W-1:0] lft_peak,
  output logic [SAMPLE_W-1:0] rht_peak,
  output logic [CNT_W-1:0]    lft_freq_err,
  output logic [CNT_W-1:0]    rht_freq_err,
  output logic [CNT_W-1:0]    lft_ampl_err,
  output logic [CNT_W-1:0]    rht_ampl_err
);

  audio_chan_mon #(
    .SMOOTH_LOG2(SMOOTH_LOG2), .CNT_W(CNT_W),
    .MIN_PERIOD(MIN_PERIOD), .MAX_PERIOD(MAX_PERIOD),
    .MIN_AMPL(MIN_AMPL), .MAX_AMPL(MAX_AMPL)
  ) u_lft (
    .clk(clk), .rst(rst), .clr(clr), .smpl_vld(smpl_vld), .smpl(lft_smpl),
    .meas_vld(lft_meas_vld), .period(lft_period), .peak(lft_peak),
    .freq_err(lft_freq_err), .ampl_err(lft_ampl_err)
  );

  audio_chan_mon #(
    .SMOOTH_LOG2(SMOOTH_LOG2), .CNT_W(CNT_W),
    .MIN_PERIOD(MIN_PERIOD), .MAX_PERIOD(MAX_PERIOD),
    .MIN_AMPL(MIN_AMPL), .MAX_AMPL(MAX_AMPL)
  ) u_rht (
    .clk(clk), .rst(rst), .clr(clr), .smpl_vld(smpl_vld), .smpl(rht_smpl),
    .meas_vld(rht_meas_vld), .period(rht_period), .peak(rht_peak),
    .freq_err(rht_freq_err), .ampl_err(rht_ampl_err)
  );

endmodule
